// File: rtl/execute_alu_unit.sv
// execute_alu_unit: combinational execute-stage ALU and branch adder with HI/LO registers.
// Multiply and HI/LO access exist only when EXEC_ALU_MULDIV_EN is defined.
module execute_alu_unit #(
    parameter logic [31:0] HILO_INIT = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ALUOp,
    input  logic [5:0]  Funct,
    input  logic [4:0]  Shamt,
    input  logic [4:0]  RsField,
    input  logic        Valid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] PCPlus4,
    input  logic [31:0] Offset,
    output logic [31:0] Result,
    output logic        Zero,
    output logic [31:0] BranchTarget,
    output logic [63:0] MultResult,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    logic [31:0] r_res;

    function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] t;
        t = {v, v} >> s;
        return t[31:0];
    endfunction

`ifdef EXEC_ALU_MULDIV_EN
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] prod;
    logic        is_mul;
    logic        unused_ok;
    assign unused_ok = ^RsField[4:1];
    // Sign-extending to 64 bits makes the low 64 bits of the unsigned product the signed product
    assign prod   = Funct[0] ? {32'b0, A} * {32'b0, B}
                             : {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign is_mul = (ALUOp == 5'd0) && (Funct == 6'h18 || Funct == 6'h19);
    assign MultResult = is_mul ? prod : 64'd0;
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (Valid && ALUOp == 5'd0) begin
            if (is_mul) {hi_d, lo_d} = prod;
            if (Funct == 6'h11) hi_d = A;
            if (Funct == 6'h13) lo_d = A;
        end
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_q <= HILO_INIT;
            lo_q <= HILO_INIT;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign HI = hi_q;
    assign LO = lo_q;
`else
    logic unused_ok;
    assign unused_ok  = ^{Clk, Reset, Valid, RsField[4:1]};
    assign MultResult = 64'd0;
    assign HI = HILO_INIT;
    assign LO = HILO_INIT;
`endif

    always_comb begin
        case (Funct)
            6'h00:        r_res = B << Shamt;
            6'h02:        r_res = RsField[0] ? rotr(B, Shamt) : B >> Shamt;
            6'h03:        r_res = $signed(B) >>> Shamt;
            6'h04:        r_res = B << A[4:0];
            6'h06:        r_res = Shamt[0] ? rotr(B, A[4:0]) : B >> A[4:0];
            6'h07:        r_res = $signed(B) >>> A[4:0];
            6'h20, 6'h21: r_res = A + B;
            6'h22, 6'h23: r_res = A - B;
            6'h24:        r_res = A & B;
            6'h25:        r_res = A | B;
            6'h26:        r_res = A ^ B;
            6'h27:        r_res = ~(A | B);
            6'h2A:        r_res = {31'b0, $signed(A) < $signed(B)};
            6'h2B:        r_res = {31'b0, A < B};
`ifdef EXEC_ALU_MULDIV_EN
            6'h10:        r_res = hi_q;
            6'h12:        r_res = lo_q;
            6'h18, 6'h19: r_res = prod[31:0];
`endif
            default:      r_res = 32'd0;
        endcase
    end

    always_comb begin
        case (ALUOp)
            5'd0:    Result = r_res;
            5'd1:    Result = A + B;
            5'd2:    Result = A - B;
            5'd3:    Result = A & B;
            5'd4:    Result = A | {16'b0, B[15:0]};
            5'd5:    Result = A ^ {16'b0, B[15:0]};
            5'd6:    Result = {31'b0, $signed(A) < $signed(B)};
            5'd7:    Result = {31'b0, A < B};
            5'd8:    Result = {B[15:0], 16'b0};
            default: Result = 32'd0;
        endcase
    end

    assign Zero         = (Result == 32'd0);
    assign BranchTarget = PCPlus4 + {Offset[29:0], 2'b00};
endmodule

// File: tb/tb_execute_alu_unit.sv
// tb_execute_alu_unit: randomized and directed checks of execute_alu_unit against a behavioural model.
module tb_execute_alu_unit;
    localparam logic [31:0] INIT = 32'hA5A5_0F0F;
`ifdef EXEC_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        Clk, Reset, Valid;
    logic [4:0]  ALUOp, Shamt, RsField;
    logic [5:0]  Funct;
    logic [31:0] A, B, PCPlus4, Offset, Result, BranchTarget, HI, LO;
    logic        Zero;
    logic [63:0] MultResult;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi = INIT;
    logic [31:0] m_lo = INIT;

    execute_alu_unit #(.HILO_INIT(INIT)) dut (
        .Clk(Clk), .Reset(Reset), .ALUOp(ALUOp), .Funct(Funct), .Shamt(Shamt),
        .RsField(RsField), .Valid(Valid), .A(A), .B(B), .PCPlus4(PCPlus4),
        .Offset(Offset), .Result(Result), .Zero(Zero), .BranchTarget(BranchTarget),
        .MultResult(MultResult), .HI(HI), .LO(LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (f[0]) return ua * ub;
        return sa * sb;
    endfunction

    function automatic logic [31:0] rot(input logic [31:0] v, input int s);
        if (s == 0) return v;
        return (v >> s) | (v << (32 - s));
    endfunction

    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [5:0] f, input logic [4:0] sh,
                                            input logic [4:0] rs, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0] p;
        int va;
        sa = a;
        sb = b;
        va = int'(a % 32);
        p  = ref_prod(f, a, b);
        case (op)
            5'd1: return a + b;
            5'd2: return a - b;
            5'd3: return a & b;
            5'd4: return a | (b % 65536);
            5'd5: return a ^ (b % 65536);
            5'd6: return (sa < sb) ? 32'd1 : 32'd0;
            5'd7: return (a < b) ? 32'd1 : 32'd0;
            5'd8: return (b % 65536) * 65536;
            5'd0: ;
            default: return 32'd0;
        endcase
        case (f)
            6'h00: return b << sh;
            6'h02: return rs[0] ? rot(b, int'(sh)) : b >> sh;
            6'h03: return sb >>> sh;
            6'h04: return b << va;
            6'h06: return sh[0] ? rot(b, va) : b >> va;
            6'h07: return sb >>> va;
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h10: return MD ? m_hi : 32'd0;
            6'h12: return MD ? m_lo : 32'd0;
            6'h18, 6'h19: return MD ? p[31:0] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic [4:0] op, input logic [5:0] f, input logic [4:0] sh, input logic [4:0] rs,
                        input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off);
        logic [31:0] er;
        logic [63:0] ep;
        logic        is_mul;
        ALUOp = op; Funct = f; Shamt = sh; RsField = rs; Valid = v;
        A = a; B = b; PCPlus4 = pc; Offset = off;
        #1;
        is_mul = MD && op == 5'd0 && (f == 6'h18 || f == 6'h19);
        er = ref_res(op, f, sh, rs, a, b);
        ep = is_mul ? ref_prod(f, a, b) : 64'd0;
        check($sformatf("result op=%0d f=%h", op, f), {32'd0, Result}, {32'd0, er});
        check($sformatf("zero op=%0d f=%h", op, f), {63'd0, Zero}, {63'd0, er == 32'd0});
        check("btarget", {32'd0, BranchTarget}, {32'd0, pc + off * 32'd4});
        check($sformatf("multresult f=%h", f), MultResult, ep);
        check("hi", {32'd0, HI}, {32'd0, m_hi});
        check("lo", {32'd0, LO}, {32'd0, m_lo});
        @(posedge Clk);
        if (!Reset && MD && v && op == 5'd0) begin
            if (is_mul) {m_hi, m_lo} = ep;
            if (f == 6'h11) m_hi = a;
            if (f == 6'h13) m_lo = a;
        end
        #2;
    endtask

    logic [5:0] pool [22] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18,
                              6'h19, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    initial begin
        Reset = 1'b1; Valid = 1'b0; ALUOp = '0; Funct = '0; Shamt = '0; RsField = '0;
        A = '0; B = '0; PCPlus4 = '0; Offset = '0;
        #3;
        check("reset_hi", {32'd0, HI}, {32'd0, INIT});
        check("reset_lo", {32'd0, LO}, {32'd0, INIT});
        // A mult while Reset is held must be discarded
        step(5'd0, 6'h18, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        Reset = 1'b0;
        #1;
        check("reset_wins_hi", {32'd0, HI}, {32'd0, INIT});
        step(5'd0, 6'h10, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
        step(5'd0, 6'h20, 5'd0, 5'd0, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        check("add_wrap", {32'd0, Result}, 64'h8000_0000);
        check("add_zero_flag", {63'd0, Zero}, 64'd0);
        step(5'd0, 6'h2A, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        check("slt_neg", {32'd0, Result}, 64'd1);
        step(5'd0, 6'h2B, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        check("sltu_big", {32'd0, Result}, 64'd0);
        step(5'd0, 6'h02, 5'd4, 5'd1, 1'b1, 32'd0, 32'h0000_000F, 32'd0, 32'd0);
        check("rotr4", {32'd0, Result}, 64'hF000_0000);
        step(5'd0, 6'h02, 5'd4, 5'd0, 1'b1, 32'd0, 32'h0000_000F, 32'd0, 32'd0);
        check("srl4", {32'd0, Result}, 64'd0);
        step(5'd1, 6'h00, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'h0000_0010, 32'hFFFF_FFFF);
        check("btarget_neg", {32'd0, BranchTarget}, 64'h0000_000C);
        step(5'd0, 6'h18, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        check("mult_invalid_hi", {32'd0, HI}, {32'd0, INIT});
        check("mult_invalid_lo", {32'd0, LO}, {32'd0, INIT});
        step(5'd0, 6'h18, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        step(5'd0, 6'h10, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
`ifdef EXEC_ALU_MULDIV_EN
        check("mfhi_after_mult", {32'd0, Result}, 64'hFFFF_FFFF);
        check("lo_after_mult", {32'd0, LO}, 64'hFFFF_FFFA);
`endif
        // Asynchronous reset mid-cycle restores HI/LO without waiting for an edge
        Reset = 1'b1;
        #1;
        check("async_rst_hi", {32'd0, HI}, {32'd0, INIT});
        check("async_rst_lo", {32'd0, LO}, {32'd0, INIT});
        m_hi = INIT;
        m_lo = INIT;
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  op;
            logic [5:0]  f;
            logic [31:0] a, b;
            op = ($urandom_range(0, 6) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            f  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : pool[$urandom_range(0, 21)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 40));
            step(op, f, 5'($urandom), 5'($urandom), $urandom_range(0, 3) != 0, a, b, $urandom, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
